// File: rtl/rv_iopmp_pkg.sv
// rv_iopmp_pkg: shared entry-config, scan-error and scanner-state types.
package rv_iopmp_pkg;
   typedef enum logic [1:0] {MODE_OFF, MODE_TOR, MODE_NA4, MODE_NAPOT} mode_t;
   typedef struct packed {
      mode_t mode;
      logic  r;
      logic  w;
      logic  x;
   } entry_cfg_t;
   // Encoded so that a larger value is a more severe non-priority error.
   typedef enum logic [1:0] {ERR_NONE, ERR_NO_HIT, ERR_PERM, ERR_PARTIAL} scan_err_e;
   typedef enum logic [1:0] {ST_IDLE, ST_PREFETCH, ST_SCAN, ST_RESP} scan_state_e;
endpackage

// File: rtl/rv_iopmp_entry.sv
// rv_iopmp_entry: single IOPMP entry matcher.
//   addr_i/num_bytes_i   transaction byte range [addr, addr+num_bytes)
//   entry_addr*_i        entry address register ({addrh,addr} holds byte address >> 2)
//   prev_addr_i          previous entry address register (TOR lower bound)
//   mode_i               OFF/TOR/NA4/NAPOT
//   match_o              some byte of the transaction falls in the region
//   allow_o              every byte of the transaction falls in the region
module rv_iopmp_entry
   import rv_iopmp_pkg::*;
#(
   parameter int LEN        = 32,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic [ADDR_WIDTH-1:0]            addr_i,
   input  logic [$clog2(DATA_WIDTH/8):0]    num_bytes_i,
   input  logic [LEN-1:0]                   entry_addr_i,
   input  logic [LEN-1:0]                   entry_addrh_i,
   input  logic [2*LEN-1:0]                 prev_addr_i,
   input  mode_t                            mode_i,
   output logic                             match_o,
   output logic                             allow_o
);
   localparam int CHECK_LEN = 2*LEN+2;
   localparam int CW = CHECK_LEN+1;
   localparam logic [2*LEN-1:0] ONE_E = 1;
   localparam logic [CW-1:0] ONE_C = 1;
   localparam logic [CW-1:0] FOUR_C = 4;
   logic [2*LEN-1:0] ent, msk;
   logic [CW-1:0] s, e, cur, lo, hi;
   logic on;
   assign ent = {entry_addrh_i, entry_addr_i};
   // Trailing ones plus the first zero: the NAPOT size mask in word units.
   assign msk = ent ^ (ent + ONE_E);
   assign s = CW'(addr_i);
   assign e = s + CW'(num_bytes_i);
   assign cur = {1'b0, ent, 2'b00};
   assign lo = mode_i == MODE_TOR   ? {1'b0, prev_addr_i, 2'b00} :
               mode_i == MODE_NAPOT ? {1'b0, ent & ~msk, 2'b00} : cur;
   assign hi = mode_i == MODE_TOR   ? cur :
               mode_i == MODE_NAPOT ? {1'b0, ent | msk, 2'b11} + ONE_C : cur + FOUR_C;
   assign on = mode_i != MODE_OFF && lo < hi;
   assign match_o = on && s < hi && e > lo;
   assign allow_o = on && s >= lo && e <= hi;
endmodule

// File: rtl/rv_iopmp_entry_scanner.sv
// rv_iopmp_entry_scanner: walks an entry range through a 1-cycle table port and resolves one allow/deny decision.
//   req_*            transaction and MD range, accepted in IDLE (req_ready_o)
//   prio_entry_num_i entries below this index are priority entries
//   entry_*          table read strobe/index out, entry data back one cycle later
//   rsp_*            decision, held until rsp_ready_i
module rv_iopmp_entry_scanner
   import rv_iopmp_pkg::*;
#(
   parameter int NUM_ENTRY  = 16,
   parameter int IDX_W      = $clog2(NUM_ENTRY),
   parameter int LEN        = 32,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic [ADDR_WIDTH-1:0]          req_addr_i,
   input  logic [$clog2(DATA_WIDTH/8):0]  req_num_bytes_i,
   input  logic                           req_write_i,
   input  logic [IDX_W-1:0]               req_start_idx_i,
   input  logic [IDX_W:0]                 req_end_idx_i,
   input  logic [IDX_W:0]                 prio_entry_num_i,
   output logic                           entry_req_o,
   output logic [IDX_W-1:0]               entry_idx_o,
   input  logic [LEN-1:0]                 entry_addr_i,
   input  logic [LEN-1:0]                 entry_addrh_i,
   input  entry_cfg_t                     entry_cfg_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic                           rsp_allow_o,
   output logic [IDX_W-1:0]               rsp_entry_idx_o,
   output scan_err_e                      rsp_err_o
);
   localparam logic [IDX_W:0] ONE_I = 1;
   scan_state_e state, state_n;
   logic [IDX_W:0] rd_idx, ev_idx, end_q, prio_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [$clog2(DATA_WIDTH/8):0] nb_q;
   logic wr_q, vld;
   logic [2*LEN-1:0] prev_q;
   scan_err_e worst_q, w_err, cand, f_err;
   logic [IDX_W-1:0] worst_idx_q, w_idx, f_idx;
   logic match, allow, perm, pri, ok, ev, hit, fin, worse;
   logic unused_x;
   assign unused_x = entry_cfg_i.x;
   rv_iopmp_entry #(.LEN(LEN), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_entry (
      .addr_i        (addr_q),
      .num_bytes_i   (nb_q),
      .entry_addr_i  (entry_addr_i),
      .entry_addrh_i (entry_addrh_i),
      .prev_addr_i   (prev_q),
      .mode_i        (entry_cfg_i.mode),
      .match_o       (match),
      .allow_o       (allow)
   );
   // vld marks that the table data on the entry_* inputs answers last cycle's read.
   assign ev = state == ST_SCAN && vld;
   assign perm = wr_q ? entry_cfg_i.w : entry_cfg_i.r;
   assign pri = ev_idx < prio_q;
   assign ok = match && allow && perm;
   assign hit = ev && (pri ? match : ok);
   assign fin = ev && (ev_idx + ONE_I) == end_q;
   assign cand = allow ? ERR_PERM : ERR_PARTIAL;
   assign worse = ev && !pri && match && !ok && cand > worst_q;
   assign w_err = worse ? cand : worst_q;
   assign w_idx = worse ? ev_idx[IDX_W-1:0] : worst_idx_q;
   assign f_err = hit ? (ok ? ERR_NONE : cand) : (w_err == ERR_NONE ? ERR_NO_HIT : w_err);
   assign f_idx = hit ? ev_idx[IDX_W-1:0] : (w_err == ERR_NONE ? '0 : w_idx);
   assign req_ready_o = state == ST_IDLE;
   assign rsp_valid_o = state == ST_RESP;
   assign entry_req_o = state == ST_PREFETCH || (state == ST_SCAN && rd_idx < end_q && !hit);
   assign entry_idx_o = rd_idx[IDX_W-1:0];
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= ST_IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:     state_n = !req_valid_i ? ST_IDLE :
                                {1'b0, req_start_idx_i} >= req_end_idx_i ? ST_RESP :
                                req_start_idx_i != '0 ? ST_PREFETCH : ST_SCAN;
         ST_PREFETCH: state_n = vld ? ST_SCAN : ST_PREFETCH;
         ST_SCAN:     state_n = hit || fin ? ST_RESP : ST_SCAN;
         default:     state_n = rsp_ready_i ? ST_IDLE : ST_RESP;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld <= 1'b0;
         rd_idx <= '0;
         ev_idx <= '0;
         end_q <= '0;
         prio_q <= '0;
         addr_q <= '0;
         nb_q <= '0;
         wr_q <= 1'b0;
         prev_q <= '0;
         worst_q <= ERR_NONE;
         worst_idx_q <= '0;
         rsp_allow_o <= 1'b0;
         rsp_entry_idx_o <= '0;
         rsp_err_o <= ERR_NONE;
      end else begin
         vld <= entry_req_o;
         if (entry_req_o) begin
            rd_idx <= rd_idx + ONE_I;
            ev_idx <= rd_idx;
         end
         if (state == ST_IDLE && req_valid_i) begin
            // Start one entry early when a TOR lower bound must be fetched first.
            rd_idx <= {1'b0, req_start_idx_i} - {{IDX_W{1'b0}}, |req_start_idx_i};
            end_q <= req_end_idx_i;
            prio_q <= prio_entry_num_i;
            addr_q <= req_addr_i;
            nb_q <= req_num_bytes_i;
            wr_q <= req_write_i;
            prev_q <= '0;
            worst_q <= ERR_NONE;
            worst_idx_q <= '0;
            rsp_allow_o <= 1'b0;
            rsp_entry_idx_o <= '0;
            rsp_err_o <= ERR_NO_HIT;
         end
         if ((state == ST_PREFETCH && vld) || ev) prev_q <= {entry_addrh_i, entry_addr_i};
         if (ev) begin
            worst_q <= w_err;
            worst_idx_q <= w_idx;
         end
         if (hit || fin) begin
            rsp_allow_o <= hit && ok;
            rsp_entry_idx_o <= f_idx;
            rsp_err_o <= f_err;
         end
      end
   end
endmodule

// File: tb/tb_rv_iopmp_entry_scanner.sv
// tb_rv_iopmp_entry_scanner: directed self-checking bench with a 1-cycle entry table model.
module tb_rv_iopmp_entry_scanner;
   import rv_iopmp_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_valid = 1'b0;
   logic req_ready;
   logic [63:0] req_addr = '0;
   logic [3:0] req_nb = '0;
   logic req_write = 1'b0;
   logic [3:0] req_start = '0;
   logic [4:0] req_end = '0;
   logic [4:0] prio = '0;
   logic entry_req;
   logic [3:0] entry_idx;
   logic [31:0] entry_addr = '0;
   logic [31:0] entry_addrh = '0;
   entry_cfg_t entry_cfg = '0;
   logic rsp_valid;
   logic rsp_ready = 1'b0;
   logic rsp_allow;
   logic [3:0] rsp_idx;
   scan_err_e rsp_err;
   logic [31:0] t_addr [16];
   entry_cfg_t t_cfg [16];
   int n_cmp = 0;
   int n_bad = 0;

   rv_iopmp_entry_scanner dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_addr_i       (req_addr),
      .req_num_bytes_i  (req_nb),
      .req_write_i      (req_write),
      .req_start_idx_i  (req_start),
      .req_end_idx_i    (req_end),
      .prio_entry_num_i (prio),
      .entry_req_o      (entry_req),
      .entry_idx_o      (entry_idx),
      .entry_addr_i     (entry_addr),
      .entry_addrh_i    (entry_addrh),
      .entry_cfg_i      (entry_cfg),
      .rsp_valid_o      (rsp_valid),
      .rsp_ready_i      (rsp_ready),
      .rsp_allow_o      (rsp_allow),
      .rsp_entry_idx_o  (rsp_idx),
      .rsp_err_o        (rsp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (entry_req) begin
         entry_addr <= t_addr[entry_idx];
         entry_addrh <= '0;
         entry_cfg <= t_cfg[entry_idx];
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 16; i++) begin
         t_addr[i] = '0;
         t_cfg[i] = '{mode: MODE_OFF, r: 1'b0, w: 1'b0, x: 1'b0};
      end
   endtask

   task automatic set(input int i, input logic [31:0] a, input mode_t m, input bit r, input bit w);
      t_addr[i] = a;
      t_cfg[i] = '{mode: m, r: r, w: w, x: 1'b0};
   endtask

   task automatic issue(input int s, input int e, input int p, input logic [63:0] a, input int nb, input bit wr);
      req_start = 4'(s);
      req_end = 5'(e);
      prio = 5'(p);
      req_addr = a;
      req_nb = 4'(nb);
      req_write = wr;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic run(input string tag, input int s, input int e, input int p, input logic [63:0] a,
                      input int nb, input bit wr, input int lat_x, input int allow_x, input int idx_x,
                      input int err_x, input int hold);
      int lat;
      issue(s, e, p, a, nb, wr);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, ".lat"}, lat, lat_x);
      for (int i = 0; i < hold; i++) begin
         chk({tag, ".hold_valid"}, int'(rsp_valid), 1);
         chk({tag, ".hold_ready"}, int'(req_ready), 0);
         chk({tag, ".hold_err"}, int'(rsp_err), err_x);
         @(negedge clk);
      end
      chk({tag, ".allow"}, int'(rsp_allow), allow_x);
      chk({tag, ".idx"}, int'(rsp_idx), idx_x);
      chk({tag, ".err"}, int'(rsp_err), err_x);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, ".idle"}, int'(req_ready), 1);
      chk({tag, ".valid_low"}, int'(rsp_valid), 0);
   endtask

   initial begin
      clr();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst.ready", int'(req_ready), 1);
      chk("rst.entry_req", int'(entry_req), 0);
      chk("rst.valid", int'(rsp_valid), 0);
      chk("rst.allow", int'(rsp_allow), 0);
      chk("rst.idx", int'(rsp_idx), 0);
      chk("rst.err", int'(rsp_err), int'(ERR_NONE));

      set(0, 32'h3FF, MODE_NAPOT, 1, 0);
      run("napot0", 0, 4, 4, 64'h100, 8, 0, 3, 1, 0, int'(ERR_NONE), 0);

      clr();
      set(2, 32'h400, MODE_TOR, 1, 0);
      run("tor2", 0, 4, 4, 64'h100, 8, 0, 5, 1, 2, int'(ERR_NONE), 0);

      clr();
      set(0, 32'h40, MODE_NA4, 1, 0);
      run("pri_partial", 0, 4, 4, 64'h100, 8, 0, 3, 0, 0, int'(ERR_PARTIAL), 0);
      set(1, 32'h3FF, MODE_NAPOT, 1, 1);
      run("nonpri_skip", 0, 4, 0, 64'h100, 8, 0, 4, 1, 1, int'(ERR_NONE), 0);

      clr();
      set(1, 32'h40, MODE_OFF, 0, 0);
      set(2, 32'h80, MODE_TOR, 1, 0);
      run("prefetch_perm", 2, 3, 4, 64'h120, 8, 1, 4, 0, 2, int'(ERR_PERM), 0);

      run("empty_range", 5, 5, 4, 64'h100, 8, 0, 1, 0, 0, int'(ERR_NO_HIT), 3);

      clr();
      run("no_hit", 0, 4, 4, 64'h100, 8, 0, 6, 0, 0, int'(ERR_NO_HIT), 0);

      set(0, 32'h3FF, MODE_NAPOT, 1, 0);
      set(1, 32'h40, MODE_NA4, 1, 1);
      run("worst_err", 0, 3, 0, 64'h100, 8, 1, 5, 0, 1, int'(ERR_PARTIAL), 0);

      clr();
      set(15, 32'h3FF, MODE_NAPOT, 1, 0);
      run("last_entry", 12, 16, 0, 64'h100, 8, 0, 7, 1, 15, int'(ERR_NONE), 0);
      clr();
      run("end16_nohit", 12, 16, 0, 64'h100, 8, 0, 7, 0, 0, int'(ERR_NO_HIT), 0);

      issue(0, 4, 4, 64'h100, 8, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst.entry_req", int'(entry_req), 0);
      chk("midrst.valid", int'(rsp_valid), 0);
      chk("midrst.ready", int'(req_ready), 1);
      chk("midrst.err", int'(rsp_err), int'(ERR_NONE));
      rst = 1'b0;
      set(0, 32'h3FF, MODE_NAPOT, 1, 0);
      run("after_rst", 0, 4, 4, 64'h100, 8, 0, 3, 1, 0, int'(ERR_NONE), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
